ram_arb: RTL and testbench
==========================

# ram_arb

Two-port arbiter in front of the single-port word RAM. Shares the RAM between the core load/store unit (master 0) and the debug/UART loader (master 1): one access issued per cycle, fixed priority to the core with a starvation guard for the loader, optional lock for read-modify-write sequences, and a registered read-return path. Sits between the bus masters and the RAM instance in the SoC top.

## Interface

- AW, 32, address width (byte address; RAM indexes by addr[AW-1:2])
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied cycles after which master 1 wins one grant (≥1)

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- m0_req / m1_req  in  1  access request
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_lock  in  1  hold grant on master 0 after its current grant
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rdata / m1_rdata  out  DW  read data (registered)
- m0_rvalid / m1_rvalid  out  1  read data valid, one-cycle pulse
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM combinational read data

## Operation

- Requester holds req/we/addr/wdata stable until its gnt; may change or drop them the cycle after gnt.
- Selection per cycle, in order: (1) lock_r set and m0_req → master 0; (2) starve_cnt == STARVE_MAX and m1_req → master 1; (3) m0_req → master 0; (4) m1_req → master 1; else none.
- Exactly one gnt or none; never both.
- Granted master's we/addr/wdata routed to ram_*; with no grant ram_we=0, ram_addr=0, ram_wdata=0.
- Write granted: RAM commits at the clk edge ending the gnt cycle; no rvalid.
- Read granted: ram_rdata captured into owner's rdata register at that edge; owner's rvalid=1 in the following cycle only. Non-owner rdata holds its previous value.
- starve_cnt (width clog2(STARVE_MAX+1)): +1 each cycle m1_req && !m1_gnt, saturating at STARVE_MAX; cleared on m1_gnt or !m1_req.
- lock_r: set at edge when m0_gnt && m0_lock; cleared at edge when !m0_lock or !m0_req. Lock overrides starvation; starve_cnt stays saturated and master 1 wins first free cycle after lock drops.
- Reset: all outputs 0, starve_cnt=0, lock_r=0, rdata registers 0; a read granted in the reset cycle produces no rvalid.

## Timing

- Grant latency 0 cycles (gnt same cycle as req when selected).
- Read latency 1 cycle from gnt to rvalid/rdata.
- Throughput one access per cycle; back-to-back grants to the same master permitted.
- Write at cycle N, read same address at N+1 (either master) returns new data at N+2.
- Master 1 worst-case wait with m0 continuously requesting and unlocked: STARVE_MAX cycles, granted in cycle STARVE_MAX+1.

## Structure

- Shared defines header: master index constants (MST_CORE=0, MST_DBG=1), default STARVE_MAX, WriteEnable/ZeroWord already present.
- Single module; selection logic small enough to stay inline, no sub-module.

## Test plan

- Reset: assert rst 2 cycles with both req high → all gnt/rvalid/ram_we 0, rdata 0.
- m0 write 0x1234_5678 to 0x10, next cycle m0 read 0x10 → m0_gnt both cycles, m0_rvalid 1 cycle after read gnt with 0x1234_5678.
- Both req continuously, STARVE_MAX=4 → m0 granted cycles 1–4, m1 granted cycle 5, counter 0, pattern repeats.
- m0_lock high across 8 grants with m1 requesting → m1_gnt 0 throughout; m1 granted first cycle after lock drops.
- m1 read 0x20 while m0 idle → m1_gnt same cycle, m1_rvalid next cycle, m0_rvalid stays 0, m0_rdata unchanged.
- rst asserted in cycle after a read gnt → rvalid 0, rdata 0 following reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared constants and types for the two-master RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int   MST_CORE           = 0;
    localparam int   MST_DBG            = 1;
    localparam int   STARVE_MAX_DEFAULT = 4;
    localparam logic WRITE_ENABLE       = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    // Per-cycle RAM owner
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CORE = 2'd1,
        SEL_DBG  = 2'd2
    } sel_e;

endpackage
`default_nettype wire

// File: rtl/ram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_if
// Purpose  : Bus bundle between the two masters, the arbiter and the RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_gnt;
    logic [DW-1:0] m0_rdata;
    logic          m0_rvalid;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic [DW-1:0] m1_rdata;
    logic          m1_rvalid;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // Environment side: both masters plus the RAM instance
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata, m1_rvalid,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

endinterface
`default_nettype wire

// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb
// Purpose  : Fixed-priority arbiter (core over loader) with starvation guard,
//            read-modify-write lock and registered read return.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    ram_arb_if.slave  bus
);

    localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_SAT = c_CNT_W'(STARVE_MAX);

    sel_e               w_sel;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_wdata;
    logic               w_rd_core;
    logic               w_rd_dbg;

    logic [c_CNT_W-1:0] r_starve;
    logic               r_lock;
    logic [DW-1:0]      r_m0_rdata;
    logic [DW-1:0]      r_m1_rdata;
    logic               r_m0_rvalid;
    logic               r_m1_rvalid;

    // Lock beats the starvation guard; nothing is granted while in reset
    always_comb begin
        w_sel = SEL_NONE;
        if (rst) begin
            w_sel = SEL_NONE;
        end else if (r_lock && bus.m0_req) begin
            w_sel = SEL_CORE;
        end else if ((r_starve == c_STARVE_SAT) && bus.m1_req) begin
            w_sel = SEL_DBG;
        end else if (bus.m0_req) begin
            w_sel = SEL_CORE;
        end else if (bus.m1_req) begin
            w_sel = SEL_DBG;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (w_sel)
            SEL_CORE: begin
                w_we    = bus.m0_we;
                w_addr  = bus.m0_addr;
                w_wdata = bus.m0_wdata;
            end
            SEL_DBG: begin
                w_we    = bus.m1_we;
                w_addr  = bus.m1_addr;
                w_wdata = bus.m1_wdata;
            end
            default: begin
                w_we    = 1'b0;
            end
        endcase
    end

    assign w_rd_core = (w_sel == SEL_CORE) && (bus.m0_we != WRITE_ENABLE);
    assign w_rd_dbg  = (w_sel == SEL_DBG)  && (bus.m1_we != WRITE_ENABLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve    <= '0;
            r_lock      <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            if (!bus.m1_req || (w_sel == SEL_DBG)) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_SAT) begin
                r_starve <= r_starve + 1'b1;
            end
            // Lock arms on a locked core grant and persists while the core keeps requesting
            r_lock      <= bus.m0_lock && bus.m0_req && (r_lock || (w_sel == SEL_CORE));
            r_m0_rvalid <= w_rd_core;
            r_m1_rvalid <= w_rd_dbg;
            if (w_rd_core) begin
                r_m0_rdata <= bus.ram_rdata;
            end
            if (w_rd_dbg) begin
                r_m1_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.m0_gnt    = (w_sel == SEL_CORE);
    assign bus.m1_gnt    = (w_sel == SEL_DBG);
    assign bus.ram_we    = w_we;
    assign bus.ram_addr  = w_addr;
    assign bus.ram_wdata = w_wdata;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;
    assign bus.m0_rvalid = r_m0_rvalid;
    assign bus.m1_rvalid = r_m1_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arb
// Purpose  : Directed self-checking bench for ram_arb with a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arb;
    import ram_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ram_arb_if #(.AW(32), .DW(32)) bus ();

    ram_arb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        return 32'hA500_0000 | 32'(idx);
    endfunction

    // RAM model: combinational read, write at the clock edge
    logic [31:0] ram_mem [256];
    assign bus.ram_rdata = ram_mem[bus.ram_addr[9:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
        end
    end

    // Bench reference memory and read-return scoreboard
    logic [31:0] ref_mem [256];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        exp_rv0, exp_rv1;
    logic [31:0] last0, last1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the expected grant pair for the currently driven inputs
    task automatic cyc(input logic e0, input logic e1, input string tag);
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        x_we = 1'b0; x_addr = '0; x_wdata = '0;
        if (e0) begin
            x_we = bus.m0_we; x_addr = bus.m0_addr; x_wdata = bus.m0_wdata;
        end else if (e1) begin
            x_we = bus.m1_we; x_addr = bus.m1_addr; x_wdata = bus.m1_wdata;
        end
        @(negedge clk);
        check({tag, ".m0_gnt"},    32'(bus.m0_gnt),    32'(e0));
        check({tag, ".m1_gnt"},    32'(bus.m1_gnt),    32'(e1));
        check({tag, ".ram_we"},    32'(bus.ram_we),    32'(x_we));
        check({tag, ".ram_addr"},  bus.ram_addr,       x_addr);
        check({tag, ".ram_wdata"}, bus.ram_wdata,      x_wdata);
        check({tag, ".m0_rvalid"}, 32'(bus.m0_rvalid), 32'(exp_rv0));
        check({tag, ".m1_rvalid"}, 32'(bus.m1_rvalid), 32'(exp_rv1));
        if (exp_rv0) begin
            if (q0.size() == 0) check({tag, ".q0_empty"}, 32'd1, 32'd0);
            else last0 = q0.pop_front();
        end
        if (exp_rv1) begin
            if (q1.size() == 0) check({tag, ".q1_empty"}, 32'd1, 32'd0);
            else last1 = q1.pop_front();
        end
        check({tag, ".m0_rdata"}, bus.m0_rdata, last0);
        check({tag, ".m1_rdata"}, bus.m1_rdata, last1);
        @(posedge clk);
        if (rst) begin
            exp_rv0 = 1'b0; exp_rv1 = 1'b0;
            last0 = '0; last1 = '0;
            q0.delete(); q1.delete();
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        end else begin
            exp_rv0 = e0 && !bus.m0_we;
            exp_rv1 = e1 && !bus.m1_we;
            if (exp_rv0) q0.push_back(ref_mem[bus.m0_addr[9:2]]);
            if (exp_rv1) q1.push_back(ref_mem[bus.m1_addr[9:2]]);
            if (e0 && bus.m0_we) ref_mem[bus.m0_addr[9:2]] = bus.m0_wdata;
            if (e1 && bus.m1_we) ref_mem[bus.m1_addr[9:2]] = bus.m1_wdata;
        end
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; last0 = '0; last1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset with both masters requesting
        rst = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = '0; bus.m0_lock = 1'b0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h4; bus.m1_wdata = '0;
        cyc(1'b0, 1'b0, "rst0");
        cyc(1'b0, 1'b0, "rst1");
        rst = 1'b0; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        cyc(1'b0, 1'b0, "idle");

        // Core write then read-back
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h10; bus.m0_wdata = 32'h1234_5678;
        cyc(1'b1, 1'b0, "m0_wr");
        bus.m0_we = 1'b0;
        cyc(1'b1, 1'b0, "m0_rd");
        bus.m0_req = 1'b0;
        cyc(1'b0, 1'b0, "m0_rv");
        check("m0_rdata_wr_rd", bus.m0_rdata, 32'h1234_5678);

        // Both requesting: four core grants, then one loader grant, repeating
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h40;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h44;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, "starve_m0");
            cyc(1'b0, 1'b1, "starve_m1");
        end

        // Lock across 8 grants, released together with the core request
        bus.m0_lock = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, "lock");
        bus.m0_lock = 1'b0; bus.m0_req = 1'b0;
        cyc(1'b0, 1'b1, "lock_rel");

        // Lock dropped while the core keeps requesting: lock_r still holds one cycle
        bus.m0_req = 1'b1; bus.m0_lock = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, "lock2");
        bus.m0_lock = 1'b0;
        cyc(1'b1, 1'b0, "lock2_tail");
        cyc(1'b0, 1'b1, "lock2_after");
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        cyc(1'b0, 1'b0, "lock2_idle");

        // Core write at N, loader read of same address at N+1
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'hCAFE_F00D;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h20;
        cyc(1'b1, 1'b0, "x_wr");
        bus.m0_req = 1'b0; bus.m0_we = 1'b0;
        cyc(1'b0, 1'b1, "x_rd");
        bus.m1_req = 1'b0;
        cyc(1'b0, 1'b0, "x_rv");
        check("m1_rdata_cross", bus.m1_rdata, 32'hCAFE_F00D);

        // Loader alone: write, read back, core side untouched
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h24; bus.m1_wdata = 32'h0BAD_BEEF;
        cyc(1'b0, 1'b1, "m1_wr");
        bus.m1_we = 1'b0;
        cyc(1'b0, 1'b1, "m1_rd");
        bus.m1_req = 1'b0;
        cyc(1'b0, 1'b0, "m1_rv");
        check("m1_rdata_alone", bus.m1_rdata, 32'h0BAD_BEEF);
        check("m0_rdata_held", bus.m0_rdata, 32'hA500_0010);

        // Reset in the cycle after a read grant
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        cyc(1'b1, 1'b0, "rr_rd");
        bus.m0_req = 1'b0; rst = 1'b1;
        cyc(1'b0, 1'b0, "rr_rst");
        rst = 1'b0;
        cyc(1'b0, 1'b0, "rr_post");
        check("post_rst_m0_rdata", bus.m0_rdata, 32'h0);
        check("post_rst_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
